instr_feeder: RTL

- Program sequencer that drives the simple processor's instruction input.
- Holds a small program memory of 16-bit words.
- On Start, it issues each instruction on Din with a one-cycle Run pulse and supplies the immediate word for mvi.
- It waits for the processor's Done before moving on. It replaces manual switch/Run stimulus on the board and in benches.

---
 rtl/instr_feeder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_feeder.sv
// Program sequencer: streams a stored program into the simple processor,
// pulsing Run once per instruction and handing over the mvi immediate word.
module instr_feeder #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          Done,
    output logic [15:0]   Din,
    output logic          Run,
    output logic          Busy,
    output logic          Finished,
    output logic          Error,
    output logic [AW:0]   pc
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0] OP_MVI = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        IMM,
        WAIT,
        DONE_ST,
        ERR
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_mem [DEPTH];
    logic [AW:0]   r_pc;
    logic [AW:0]   r_len;
    logic [CW-1:0] r_cnt;
    logic          r_finished;
    logic          r_error;
    logic [15:0]   w_word;
    logic [AW:0]   w_pcInc;
    logic          w_lastWord;
    logic          w_busy;

    assign w_word     = r_mem[r_pc[AW-1:0]];
    assign w_pcInc    = r_pc + (AW+1)'(1);
    assign w_lastWord = (w_pcInc == r_len);
    assign w_busy     = (r_state == ISSUE) || (r_state == IMM) || (r_state == WAIT);

    // Program memory is only writable between runs so a program cannot change under itself.
    always_ff @(posedge clk) begin
        if (prog_we && !w_busy) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (Start && (prog_len != '0)) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_word[8:6] == OP_MVI) begin
                    w_next = w_lastWord ? ERR : IMM;
                end else begin
                    w_next = WAIT;
                end
            end
            IMM: begin
                if (Done) begin
                    w_next = w_lastWord ? DONE_ST : ISSUE;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (Done) begin
                    w_next = (r_pc == r_len) ? DONE_ST : ISSUE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = ERR;
                end
            end
            DONE_ST: w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_finished <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        if (prog_len == '0) begin
                            r_finished <= 1'b1;
                        end else begin
                            r_len      <= prog_len;
                            r_pc       <= '0;
                            r_finished <= 1'b0;
                            r_error    <= 1'b0;
                        end
                    end
                end
                ISSUE:   r_pc <= w_pcInc;
                IMM:     r_pc <= w_pcInc;
                default: ;
            endcase
            if (w_next == DONE_ST) begin
                r_finished <= 1'b1;
            end
            if (w_next == ERR) begin
                r_error <= 1'b1;
            end
            // Counter is zero on the first WAIT cycle, so ERR lands exactly TIMEOUT cycles after entry.
            r_cnt <= ((r_state == WAIT) && (w_next == WAIT)) ? r_cnt + 1'b1 : '0;
        end
    end

    // Strobe and bus are gated by Reset so an in-flight Run is dropped within the same cycle.
    always_comb begin
        Din = 16'h0000;
        if (!Reset && ((r_state == ISSUE) || (r_state == IMM))) begin
            Din = w_word;
        end
    end

    assign Run      = (r_state == ISSUE) && !Reset;
    assign Busy     = w_busy && !Reset;
    assign Finished = r_finished;
    assign Error    = r_error;
    assign pc       = r_pc;

endmodule
